// File: rtl/pwm_regs_pkg.sv
// Shared register map for the multi-channel PWM register file: offsets, CTRL/STATUS bit
// positions and the address field split (channel in addr[5:4], offset in addr[3:0]).
package pwm_regs_pkg;

  localparam logic [3:0] OFF_PERIOD_L    = 4'h0;
  localparam logic [3:0] OFF_PERIOD_H    = 4'h1;
  localparam logic [3:0] OFF_CTRL        = 4'h2;
  localparam logic [3:0] OFF_CMP1_L      = 4'h3;
  localparam logic [3:0] OFF_CMP1_H      = 4'h4;
  localparam logic [3:0] OFF_CMP2_L      = 4'h5;
  localparam logic [3:0] OFF_CMP2_H      = 4'h6;
  localparam logic [3:0] OFF_COUNT_RESET = 4'h7;
  localparam logic [3:0] OFF_CNT_L       = 4'h8;
  localparam logic [3:0] OFF_CNT_H       = 4'h9;
  localparam logic [3:0] OFF_PRESCALE    = 4'hA;
  localparam logic [3:0] OFF_STATUS      = 4'hB;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_UPNOTDOWN = 1;
  localparam int CTRL_PWM_EN    = 2;
  localparam int CTRL_FUNC_LSB  = 3;
  localparam int CTRL_W         = 5;

  localparam int STATUS_PENDING = 0;

  function automatic logic [1:0] addr_channel(input logic [5:0] addr);
    return addr[5:4];
  endfunction

  function automatic logic [3:0] addr_offset(input logic [5:0] addr);
    return addr[3:0];
  endfunction

endpackage

// File: rtl/pwm_regs_channel.sv
// One PWM channel's registers: 16-bit staging/shadow, CTRL, prescale, counter snapshot and
// count_reset pulse. Define PWM_REGS_SHADOW_EN to commit period/compares on period_done.
module pwm_regs_channel
  import pwm_regs_pkg::*;
#(
  parameter int RST_PULSE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [3:0]  offset,
  input  logic [7:0]  data_write,
  input  logic [15:0] counter_val,
  input  logic        period_done,
  output logic [7:0]  rd_data,
  output logic [15:0] period,
  output logic [15:0] compare1,
  output logic [15:0] compare2,
  output logic        en,
  output logic        count_reset,
  output logic        upnotdown,
  output logic        pwm_en,
  output logic [1:0]  functions,
  output logic [7:0]  prescale
);

  localparam int CW = $clog2(RST_PULSE + 1);

  logic [7:0]        per_stg_q, per_stg_d, cmp1_stg_q, cmp1_stg_d, cmp2_stg_q, cmp2_stg_d;
  logic [15:0]       period_sh_q, period_sh_d, cmp1_sh_q, cmp1_sh_d, cmp2_sh_q, cmp2_sh_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [7:0]        prescale_q, prescale_d, snap_q, snap_d;
  logic [CW-1:0]     pulse_cnt_q, pulse_cnt_d;
  logic              h_write, pending;

  assign h_write = wr_en && (offset == OFF_PERIOD_H || offset == OFF_CMP1_H || offset == OFF_CMP2_H);

  always_comb begin
    per_stg_d   = per_stg_q;
    cmp1_stg_d  = cmp1_stg_q;
    cmp2_stg_d  = cmp2_stg_q;
    period_sh_d = period_sh_q;
    cmp1_sh_d   = cmp1_sh_q;
    cmp2_sh_d   = cmp2_sh_q;
    ctrl_d      = ctrl_q;
    prescale_d  = prescale_q;
    snap_d      = snap_q;
    pulse_cnt_d = (pulse_cnt_q != '0) ? pulse_cnt_q - CW'(1) : pulse_cnt_q;
    if (wr_en) begin
      case (offset)
        OFF_PERIOD_L:    per_stg_d   = data_write;
        OFF_PERIOD_H:    period_sh_d = {data_write, per_stg_q};
        OFF_CTRL:        ctrl_d      = data_write[CTRL_W-1:0];
        OFF_CMP1_L:      cmp1_stg_d  = data_write;
        OFF_CMP1_H:      cmp1_sh_d   = {data_write, cmp1_stg_q};
        OFF_CMP2_L:      cmp2_stg_d  = data_write;
        OFF_CMP2_H:      cmp2_sh_d   = {data_write, cmp2_stg_q};
        OFF_COUNT_RESET: if (data_write[0]) pulse_cnt_d = CW'(RST_PULSE);
        OFF_PRESCALE:    prescale_d  = data_write;
        default:         ;
      endcase
    end
    // Latching the high byte on the low-byte read keeps a 16-bit counter read coherent.
    if (rd_en && offset == OFF_CNT_L) snap_d = counter_val[15:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_stg_q   <= '0;
      cmp1_stg_q  <= '0;
      cmp2_stg_q  <= '0;
      period_sh_q <= '0;
      cmp1_sh_q   <= '0;
      cmp2_sh_q   <= '0;
      ctrl_q      <= '0;
      prescale_q  <= '0;
      snap_q      <= '0;
      pulse_cnt_q <= '0;
    end else begin
      per_stg_q   <= per_stg_d;
      cmp1_stg_q  <= cmp1_stg_d;
      cmp2_stg_q  <= cmp2_stg_d;
      period_sh_q <= period_sh_d;
      cmp1_sh_q   <= cmp1_sh_d;
      cmp2_sh_q   <= cmp2_sh_d;
      ctrl_q      <= ctrl_d;
      prescale_q  <= prescale_d;
      snap_q      <= snap_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

`ifdef PWM_REGS_SHADOW_EN
  logic [15:0] period_act_q, period_act_d, cmp1_act_q, cmp1_act_d, cmp2_act_q, cmp2_act_d;
  logic        pending_q, pending_d, commit;

  // The commit uses the pre-write shadow, so an H write landing on period_done waits a period.
  always_comb begin
    commit       = period_done || !ctrl_q[CTRL_EN];
    period_act_d = period_act_q;
    cmp1_act_d   = cmp1_act_q;
    cmp2_act_d   = cmp2_act_q;
    pending_d    = pending_q;
    if (commit) begin
      period_act_d = period_sh_q;
      cmp1_act_d   = cmp1_sh_q;
      cmp2_act_d   = cmp2_sh_q;
      pending_d    = 1'b0;
    end
    if (h_write) pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_act_q <= '0;
      cmp1_act_q   <= '0;
      cmp2_act_q   <= '0;
      pending_q    <= 1'b0;
    end else begin
      period_act_q <= period_act_d;
      cmp1_act_q   <= cmp1_act_d;
      cmp2_act_q   <= cmp2_act_d;
      pending_q    <= pending_d;
    end
  end

  assign period   = period_act_q;
  assign compare1 = cmp1_act_q;
  assign compare2 = cmp2_act_q;
  assign pending  = pending_q;
`else
  logic unused_period_done;
  assign unused_period_done = period_done;
  assign period   = period_sh_q;
  assign compare1 = cmp1_sh_q;
  assign compare2 = cmp2_sh_q;
  assign pending  = 1'b0;
`endif

  assign en          = ctrl_q[CTRL_EN];
  assign upnotdown   = ctrl_q[CTRL_UPNOTDOWN];
  assign pwm_en      = ctrl_q[CTRL_PWM_EN];
  assign functions   = ctrl_q[CTRL_FUNC_LSB +: 2];
  assign prescale    = prescale_q;
  assign count_reset = (pulse_cnt_q != '0);

  always_comb begin
    rd_data = '0;
    case (offset)
      OFF_PERIOD_L: rd_data = period_sh_q[7:0];
      OFF_PERIOD_H: rd_data = period_sh_q[15:8];
      OFF_CTRL:     rd_data = {{(8 - CTRL_W){1'b0}}, ctrl_q};
      OFF_CMP1_L:   rd_data = cmp1_sh_q[7:0];
      OFF_CMP1_H:   rd_data = cmp1_sh_q[15:8];
      OFF_CMP2_L:   rd_data = cmp2_sh_q[7:0];
      OFF_CMP2_H:   rd_data = cmp2_sh_q[15:8];
      OFF_CNT_L:    rd_data = counter_val[7:0];
      OFF_CNT_H:    rd_data = snap_q;
      OFF_PRESCALE: rd_data = prescale_q;
      OFF_STATUS:   rd_data[STATUS_PENDING] = pending;
      default:      rd_data = '0;
    endcase
  end

endmodule

// File: rtl/pwm_regs_multi.sv
// Multi-channel PWM register file top: channel decode and registered read mux over
// CH_COUNT pwm_regs_channel instances. Shadowed updates selected by PWM_REGS_SHADOW_EN.
module pwm_regs_multi
  import pwm_regs_pkg::*;
#(
  parameter int CH_COUNT  = 4,
  parameter int RST_PULSE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   read,
  input  logic                   write,
  input  logic [5:0]             addr,
  input  logic [7:0]             data_write,
  output logic [7:0]             data_read,
  input  logic [CH_COUNT*16-1:0] counter_val,
  input  logic [CH_COUNT-1:0]    period_done,
  output logic [CH_COUNT*16-1:0] period,
  output logic [CH_COUNT-1:0]    en,
  output logic [CH_COUNT-1:0]    count_reset,
  output logic [CH_COUNT-1:0]    upnotdown,
  output logic [CH_COUNT*8-1:0]  prescale,
  output logic [CH_COUNT-1:0]    pwm_en,
  output logic [CH_COUNT*2-1:0]  functions,
  output logic [CH_COUNT*16-1:0] compare1,
  output logic [CH_COUNT*16-1:0] compare2
);

  logic [1:0] ch;
  logic [3:0] offset;
  logic [7:0] ch_rd_data [CH_COUNT];
  logic [7:0] data_read_q, data_read_d;

  assign ch     = addr_channel(addr);
  assign offset = addr_offset(addr);

  for (genvar i = 0; i < CH_COUNT; i++) begin : g_ch
    logic sel;
    assign sel = (ch == 2'(i));

    pwm_regs_channel #(
      .RST_PULSE (RST_PULSE)
    ) u_channel (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (write && sel),
      .rd_en       (read && sel),
      .offset      (offset),
      .data_write  (data_write),
      .counter_val (counter_val[i*16 +: 16]),
      .period_done (period_done[i]),
      .rd_data     (ch_rd_data[i]),
      .period      (period[i*16 +: 16]),
      .compare1    (compare1[i*16 +: 16]),
      .compare2    (compare2[i*16 +: 16]),
      .en          (en[i]),
      .count_reset (count_reset[i]),
      .upnotdown   (upnotdown[i]),
      .pwm_en      (pwm_en[i]),
      .functions   (functions[i*2 +: 2]),
      .prescale    (prescale[i*8 +: 8])
    );
  end

  // Channel indices with no instance never match, so they read back as zero.
  always_comb begin
    data_read_d = data_read_q;
    if (read) begin
      data_read_d = '0;
      for (int i = 0; i < CH_COUNT; i++) begin
        if (ch == 2'(i)) data_read_d = ch_rd_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_read_q <= '0;
    else        data_read_q <= data_read_d;
  end

  assign data_read = data_read_q;

endmodule

// File: tb/tb_pwm_regs_multi.sv
// Scoreboard bench for pwm_regs_multi (CH_COUNT=2, RST_PULSE=2); expectations follow
// PWM_REGS_SHADOW_EN so the same bench covers both builds.
module tb_pwm_regs_multi;

  localparam int CH = 2;
  localparam int RP = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            read = 1'b0;
  logic            write = 1'b0;
  logic [5:0]      addr = '0;
  logic [7:0]      data_write = '0;
  logic [CH*16-1:0] counter_val = '0;
  logic [CH-1:0]   period_done = '0;
  logic [7:0]      data_read;
  logic [CH*16-1:0] period, compare1, compare2;
  logic [CH-1:0]   en, count_reset, upnotdown, pwm_en;
  logic [CH*8-1:0] prescale;
  logic [CH*2-1:0] functions;

  pwm_regs_multi #(.CH_COUNT(CH), .RST_PULSE(RP)) dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
    .data_write(data_write), .data_read(data_read), .counter_val(counter_val),
    .period_done(period_done), .period(period), .en(en), .count_reset(count_reset),
    .upnotdown(upnotdown), .prescale(prescale), .pwm_en(pwm_en), .functions(functions),
    .compare1(compare1), .compare2(compare2)
  );

  always #5 clk = ~clk;

  typedef enum int {S_DATA_READ, S_PERIOD, S_EN, S_COUNT_RESET, S_UPNOTDOWN,
                    S_PRESCALE, S_PWM_EN, S_FUNCTIONS, S_COMPARE1, S_COMPARE2} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t rd_q[$];
  exp_t obs_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic rd_seen;

  function automatic logic [31:0] get_obs(input sel_e s);
    case (s)
      S_DATA_READ:   return 32'(data_read);
      S_PERIOD:      return 32'(period);
      S_EN:          return 32'(en);
      S_COUNT_RESET: return 32'(count_reset);
      S_UPNOTDOWN:   return 32'(upnotdown);
      S_PRESCALE:    return 32'(prescale);
      S_PWM_EN:      return 32'(pwm_en);
      S_FUNCTIONS:   return 32'(functions);
      S_COMPARE1:    return 32'(compare1);
      default:       return 32'(compare2);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // A read strobe seen at an edge means data_read is valid for that whole cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_seen <= 1'b0;
    else        rd_seen <= read;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        checkOutput("rd_q_underflow", 32'(data_read), 32'hDEAD_BEEF);
      end else begin
        e = rd_q.pop_front();
        checkOutput(e.name, 32'(data_read), e.exp);
      end
    end
    while (obs_q.size() > 0) begin
      e = obs_q.pop_front();
      checkOutput(e.name, get_obs(e.sel), e.exp);
    end
  end

  task automatic applyStimulus(input logic rd_i, input logic wr_i, input logic [5:0] a,
                               input logic [7:0] d, input logic [CH-1:0] pd);
    read        = rd_i;
    write       = wr_i;
    addr        = a;
    data_write  = d;
    period_done = pd;
    @(posedge clk);
    #1;
    read        = 1'b0;
    write       = 1'b0;
    period_done = '0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b1, a, d, '0);
  endtask

  task automatic rd(input logic [5:0] a, input logic [7:0] exp, input string name);
    rd_q.push_back('{name: name, sel: S_DATA_READ, exp: 32'(exp)});
    applyStimulus(1'b1, 1'b0, a, 8'h00, '0);
  endtask

  task automatic obs(input sel_e s, input logic [31:0] exp, input string name);
    obs_q.push_back('{name: name, sel: s, exp: exp});
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 6'h00, 8'h00, '0);
  endtask

  task automatic obs_all_zero(input string tag);
    obs(S_DATA_READ, 0, {tag, "_data_read"});
    obs(S_PERIOD, 0, {tag, "_period"});
    obs(S_EN, 0, {tag, "_en"});
    obs(S_COUNT_RESET, 0, {tag, "_count_reset"});
    obs(S_UPNOTDOWN, 0, {tag, "_upnotdown"});
    obs(S_PRESCALE, 0, {tag, "_prescale"});
    obs(S_PWM_EN, 0, {tag, "_pwm_en"});
    obs(S_FUNCTIONS, 0, {tag, "_functions"});
    obs(S_COMPARE1, 0, {tag, "_compare1"});
    obs(S_COMPARE2, 0, {tag, "_compare2"});
  endtask

  initial begin
    @(posedge clk);
    #1;
    obs_all_zero("reset");
    idle();
    rst_n = 1'b1;
    idle();

    $display("[TB] ch1 period write");
    wr(6'h12, 8'h01);
    wr(6'h10, 8'h34);
    wr(6'h11, 8'h12);
`ifdef PWM_REGS_SHADOW_EN
    obs(S_PERIOD, 32'h0000_0000, "ch1_period_held");
    rd(6'h1B, 8'h01, "ch1_status_pending");
    applyStimulus(1'b0, 1'b0, 6'h00, 8'h00, 2'b10);
    obs(S_PERIOD, 32'h1234_0000, "ch1_period_commit");
`else
    obs(S_PERIOD, 32'h1234_0000, "ch1_period_direct");
    rd(6'h1B, 8'h00, "ch1_status_zero");
    applyStimulus(1'b0, 1'b0, 6'h00, 8'h00, 2'b10);
    obs(S_PERIOD, 32'h1234_0000, "ch1_period_after_pd");
`endif
    rd(6'h1B, 8'h00, "ch1_status_clear");
    rd(6'h10, 8'h34, "ch1_period_l_rb");
    rd(6'h11, 8'h12, "ch1_period_h_rb");
    obs(S_EN, 32'h2, "ch1_en_only");

    $display("[TB] ch0 compare1 shadow");
    wr(6'h02, 8'h01);
    wr(6'h03, 8'h00);
    wr(6'h04, 8'h01);
`ifdef PWM_REGS_SHADOW_EN
    obs(S_COMPARE1, 32'h0, "cmp1_held");
    rd(6'h0B, 8'h01, "ch0_status_pending");
    applyStimulus(1'b0, 1'b0, 6'h00, 8'h00, 2'b01);
`else
    rd(6'h0B, 8'h00, "ch0_status_zero");
`endif
    obs(S_COMPARE1, 32'h0000_0100, "cmp1_active");
    rd(6'h0B, 8'h00, "ch0_status_after");
    rd(6'h04, 8'h01, "cmp1_h_rb");

    $display("[TB] H write coincident with period_done");
    wr(6'h05, 8'h22);
    wr(6'h06, 8'h11);
    wr(6'h05, 8'hCD);
    applyStimulus(1'b0, 1'b1, 6'h06, 8'hAB, 2'b01);
`ifdef PWM_REGS_SHADOW_EN
    obs(S_COMPARE2, 32'h0000_1122, "cmp2_old_shadow");
    rd(6'h0B, 8'h01, "cmp2_still_pending");
    applyStimulus(1'b0, 1'b0, 6'h00, 8'h00, 2'b01);
`endif
    obs(S_COMPARE2, 32'h0000_ABCD, "cmp2_new");
    rd(6'h05, 8'hCD, "cmp2_l_rb");
    rd(6'h06, 8'hAB, "cmp2_h_rb");

    $display("[TB] count_reset pulse");
    wr(6'h07, 8'h01);
    obs(S_COUNT_RESET, 32'h1, "crst_c1");
    idle();
    obs(S_COUNT_RESET, 32'h1, "crst_c2");
    idle();
    obs(S_COUNT_RESET, 32'h0, "crst_end");
    wr(6'h07, 8'h01);
    obs(S_COUNT_RESET, 32'h1, "crst_r1");
    wr(6'h07, 8'h01);
    obs(S_COUNT_RESET, 32'h1, "crst_r2");
    idle();
    obs(S_COUNT_RESET, 32'h1, "crst_r3");
    idle();
    obs(S_COUNT_RESET, 32'h0, "crst_r_end");
    wr(6'h07, 8'h00);
    obs(S_COUNT_RESET, 32'h0, "crst_write0");
    rd(6'h07, 8'h00, "crst_reads0");
    wr(6'h17, 8'h01);
    obs(S_COUNT_RESET, 32'h2, "crst_ch1");

    $display("[TB] counter snapshot");
    counter_val = {16'hBEEF, 16'h12FF};
    rd(6'h08, 8'hFF, "cnt0_l");
    counter_val[15:0] = 16'h1300;
    rd(6'h09, 8'h12, "cnt0_h_snapshot");
    rd(6'h18, 8'hEF, "cnt1_l");
    rd(6'h19, 8'hBE, "cnt1_h");

    $display("[TB] ctrl, prescale, unmapped");
    wr(6'h12, 8'h1F);
    rd(6'h12, 8'h1F, "ctrl1_rb");
    obs(S_EN, 32'h3, "en_both");
    obs(S_FUNCTIONS, 32'hC, "functions_ch1");
    obs(S_PWM_EN, 32'h2, "pwm_en_ch1");
    obs(S_UPNOTDOWN, 32'h2, "upnotdown_ch1");
    rd_q.push_back('{name: "rdwr_old_value", sel: S_DATA_READ, exp: 32'h1F});
    applyStimulus(1'b1, 1'b1, 6'h12, 8'h00, '0);
    rd(6'h12, 8'h00, "ctrl1_new_value");
    wr(6'h0A, 8'h5A);
    rd(6'h0A, 8'h5A, "prescale0_rb");
    idle();
    obs(S_DATA_READ, 32'h5A, "data_read_held");
    rd(6'h0C, 8'h00, "unmapped_0c");
    rd(6'h30, 8'h00, "ch3_absent");
    wr(6'h3A, 8'hFF);
    wr(6'h2A, 8'h77);
    obs(S_PRESCALE, 32'h005A, "absent_ch_writes_ignored");

    $display("[TB] reset mid-pulse, mid-pending");
    wr(6'h00, 8'h99);
    wr(6'h01, 8'h88);
    wr(6'h07, 8'h01);
    rst_n = 1'b0;
    obs_all_zero("midreset");
    idle();
    rst_n = 1'b1;
    rd(6'h0B, 8'h00, "post_reset_status");
    rd(6'h01, 8'h00, "post_reset_period_h");
    rd(6'h09, 8'h00, "post_reset_snapshot");
    idle();
    idle();

    checkOutput("rd_q_drained", 32'(rd_q.size()), 32'd0);
    checkOutput("obs_q_drained", 32'(obs_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
